// File: rtl/sha_digest_checker_if.sv
// Digest bus between the H0..H7 state registers, the nonce controller and the
// digest checker.
interface sha_digest_checker_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [255:0]     digest;
  logic [255:0]     target;
  logic [31:0]      nonce;
  logic             clear_found;
  logic             busy;
  logic             done;
  logic             match;
  logic             found;
  logic [31:0]      found_nonce;
  logic [CNT_W-1:0] check_count;

  modport master (
    output start, digest, target, nonce, clear_found,
    input  busy, done, match, found, found_nonce, check_count
  );

  modport slave (
    input  start, digest, target, nonce, clear_found,
    output busy, done, match, found, found_nonce, check_count
  );
endinterface

// File: rtl/sha_digest_checker.sv
// Compares a finished SHA-256 digest against the difficulty target, most
// significant word first, one 32-bit word per cycle in Bitcoin byte order.
// Latches the first winning nonce and counts completed comparisons.
module sha_digest_checker #(
  parameter int WORDS = 8,
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  sha_digest_checker_if.slave     bus
);
  localparam int IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t state, state_next;

  logic [31:0]      dig_w [WORDS];
  logic [31:0]      tgt_w [WORDS];
  logic [31:0]      nonce_q;
  logic [IDX_W-1:0] idx;

  logic             match_q;
  logic             found_q;
  logic [31:0]      found_nonce_q;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0]      hash_word;
  logic [31:0]      tgt_word;
  logic             decide;
  logic             match_next;
  logic             enter_done;
  logic             set_found;
  logic             busy_c;
  logic             done_c;

  // Word comparison for the current index; the digest word is byte-swapped
  // so the comparison runs in Bitcoin little-endian-per-word order.
  always_comb begin
    hash_word  = {dig_w[idx][7:0], dig_w[idx][15:8],
                  dig_w[idx][23:16], dig_w[idx][31:24]};
    tgt_word   = tgt_w[idx];
    decide     = (hash_word != tgt_word) || (idx == '0);
    match_next = (hash_word <= tgt_word);
    enter_done = (state == CMP) && decide;
    // A clear in the same cycle as a winning result loses to the new set.
    set_found  = enter_done && match_next && (!found_q || bus.clear_found);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CMP;
      CMP:     if (decide)    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy_c = (state != IDLE);
    done_c = (state == DONE);
  end

  // Capture, word index, result, sticky found and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= '0;
      nonce_q       <= '0;
      match_q       <= 1'b0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      cnt_q         <= '0;
      for (int unsigned i = 0; i < WORDS; i++) begin
        dig_w[i] <= '0;
        tgt_w[i] <= '0;
      end
    end else begin
      if (state == IDLE && bus.start) begin
        for (int unsigned i = 0; i < WORDS; i++) begin
          dig_w[i] <= bus.digest[32*i +: 32];
          tgt_w[i] <= bus.target[32*i +: 32];
        end
        nonce_q <= bus.nonce;
        idx     <= IDX_W'(WORDS - 1);
      end
      if (state == CMP && !decide) idx <= idx - IDX_W'(1);
      if (enter_done) begin
        match_q <= match_next;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
      if (set_found) begin
        found_q       <= 1'b1;
        found_nonce_q <= nonce_q;
      end else if (bus.clear_found) begin
        found_q       <= 1'b0;
        found_nonce_q <= '0;
      end
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.match       = match_q;
  assign bus.found       = found_q;
  assign bus.found_nonce = found_nonce_q;
  assign bus.check_count = cnt_q;
endmodule

// File: doc/sha_digest_checker.md
Name: sha_digest_checker

Overview:
- Consumes the final eight SHA-256 state words (H0..H7) once the second hash of a nonce completes.
- Compares the digest against the 256-bit difficulty target one 32-bit word per cycle, using Bitcoin byte order.
- Latches the winning nonce and reports the result to the nonce controller.
- Sits downstream of the H0..H7 state registers, on the read side of the digest bus.

Parameters:
- WORDS, 8, number of 32-bit digest words compared (fixed 8 for SHA-256).
- CNT_W, 32, width of the completed-check counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: digest and nonce inputs are valid this cycle.
- digest  input  256  {H7,H6,H5,H4,H3,H2,H1,H0}; H7 is bits [255:224].
- target  input  256  difficulty target as a big-endian 256-bit number.
- nonce  input  32  nonce that produced the digest.
- clear_found  input  1  clears the sticky found status.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when a comparison finishes.
- match  output  1  result of the last comparison; valid with done and held until the next done.
- found  output  1  sticky; set by any match.
- found_nonce  output  32  nonce of the first match since reset or clear_found.
- check_count  output  CNT_W  number of completed comparisons.

Behaviour:
- Reset (rst=1 at the clock edge) zeroes all outputs: busy, done, match, found, found_nonce, check_count. FSM goes to IDLE. Reset overrides everything, including a comparison in progress.
- FSM states:
  - IDLE: start=1 captures digest, target and nonce into internal registers, sets idx=7, goes to CMP. start is ignored in CMP and DONE (no queuing).
  - CMP: evaluates word idx.
    - Hash word = byte-swap of the captured H[idx] ({b0,b1,b2,b3} from {b3,b2,b1,b0}).
    - Target word = target[32*idx+31 : 32*idx].
    - Both compared unsigned.
    - hash < target: match=1, go to DONE.
    - hash > target: match=0, go to DONE.
    - equal and idx==0: match=1 (hash == target counts as a pass), go to DONE.
    - equal and idx>0: idx decrements, stay in CMP.
  - DONE: done=1 for exactly this cycle. check_count increments, wrapping to 0 past all-ones. Next state IDLE.
- Latency: with the start pulse at cycle T, done asserts at cycle T+1+N, where N is the number of words examined (1..8). Worst case is T+9. A new start is accepted at the earliest at cycle T+2+N.
- busy = (state != IDLE).
- found/found_nonce: on entering DONE with match=1 and found=0, set found=1 and latch the captured nonce. Later matches keep the first nonce.
  - clear_found=1 zeroes found and found_nonce next cycle.
  - clear_found in the same cycle as a match-setting DONE entry: the set wins, and found stays 1 with the new nonce.
- Captured inputs are immune to digest/target changes after the start cycle.

Test Plan:
1. rst, then digest with H7=32'h00000000 (swapped 0) and target[255:224]=32'h00000001 -> done at T+2, match=1, found=1, found_nonce=nonce, check_count=1.
2. H7=32'h01000000 (swapped 32'h00000001), target[255:224]=0 -> done at T+2, match=0, found unchanged.
3. digest == byte-swapped target in all 8 words -> done at T+9, match=1. Same digest with H0 swapped one above target word 0 -> done at T+9, match=0.
4. start pulsed again at T+1..T+5 during a case-3 comparison -> ignored; exactly one done and check_count +1. A second match with a new nonce after found=1 keeps the first found_nonce.
5. rst asserted at T+4 of an 8-word compare -> next cycle busy=0, no done, all outputs 0. A following start is processed normally.
6. clear_found coincident with a matching DONE -> found=1 with the new nonce. check_count preloaded near 2^32-1 via repeated checks (or CNT_W=4 with 16 checks) -> wraps to 0.
